ryb_display_mux: RTL



---
 rtl/ryb_disp_pkg.sv | 39 +++
 rtl/ryb_display_mux_seg7_dec.sv | 37 +++
 rtl/ryb_display_mux.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ryb_disp_pkg.sv
// Shared constants and types for the RYB 7-segment display path.
// Codes, field offsets, anode patterns and scan digit order.
package ryb_disp_pkg;

  localparam logic [4:0] CODE_BLANK = 5'd16;
  localparam logic [4:0] CODE_DASH  = 5'd17;

  localparam int R_LSB = 10;
  localparam int Y_LSB = 5;
  localparam int B_LSB = 0;

  localparam logic [2:0] AN_R   = 3'b011;
  localparam logic [2:0] AN_Y   = 3'b101;
  localparam logic [2:0] AN_B   = 3'b110;
  localparam logic [2:0] AN_OFF = 3'b111;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [14:0] FRAME_BLANK =
    {CODE_BLANK, CODE_BLANK, CODE_BLANK};

  typedef enum logic [1:0] {
    DIG_R = 2'd0,
    DIG_Y = 2'd1,
    DIG_B = 2'd2
  } dig_e;

  function automatic dig_e dig_next(input dig_e d);
    dig_e n;
    n = DIG_R;
    unique case (d)
      DIG_R:   n = DIG_Y;
      DIG_Y:   n = DIG_B;
      default: n = DIG_R;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ryb_display_mux_seg7_dec.sv
// 5-bit digit code to active-low 7-segment pattern {g,f,e,d,c,b,a}.
// Hex digits, dash, and blank for everything else.
module seg7_dec
  import ryb_disp_pkg::*;
(
  input  logic [4:0] code_i,
  output logic [6:0] seg_o
);

  logic [6:0] act;

  always_comb begin
    act = 7'b0000000;
    unique case (code_i)
      5'd0:      act = 7'b0111111;
      5'd1:      act = 7'b0000110;
      5'd2:      act = 7'b1011011;
      5'd3:      act = 7'b1001111;
      5'd4:      act = 7'b1100110;
      5'd5:      act = 7'b1101101;
      5'd6:      act = 7'b1111101;
      5'd7:      act = 7'b0000111;
      5'd8:      act = 7'b1111111;
      5'd9:      act = 7'b1101111;
      5'd10:     act = 7'b1110111;
      5'd11:     act = 7'b1111100;
      5'd12:     act = 7'b0111001;
      5'd13:     act = 7'b1011110;
      5'd14:     act = 7'b1111001;
      5'd15:     act = 7'b1110001;
      CODE_DASH: act = 7'b1000000;
      default:   act = 7'b0000000;
    endcase
    seg_o = ~act;
  end

endmodule

// File: rtl/ryb_display_mux.sv
// Three-digit multiplexed display for the RYB code bus.
// Frame-latched codes, per-slot anode guard, per-digit blink.
module ryb_display_mux
  import ryb_disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYC    = 64,
  parameter int BLINK_FRAMES = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] RYB,
  input  logic [2:0]  blink_en,
  output logic [2:0]  an,
  output logic [6:0]  seg
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int FW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  dig_e          idx_q, idx_d;
  logic [14:0]   frame_q, frame_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;
  logic [2:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic       tick, wrap;
  logic [4:0] code;
  logic       blink_bit;
  logic [2:0] an_sel;
  logic [6:0] dec_seg;

  assign tick = (cnt_q == CW'(REFRESH_DIV - 1));
  assign wrap = tick && (idx_q == DIG_B);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= DIG_R;
      frame_q <= FRAME_BLANK;
      fcnt_q  <= '0;
      phase_q <= 1'b0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    frame_d = frame_q;
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (tick) begin
      cnt_d = '0;
      idx_d = dig_next(idx_q);
    end
    // Frame wrap: latch new codes and advance the blink clock.
    if (wrap) begin
      frame_d = RYB;
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    code      = CODE_BLANK;
    blink_bit = 1'b0;
    an_sel    = AN_OFF;
    unique case (idx_q)
      DIG_R: begin
        code      = frame_q[R_LSB +: 5];
        blink_bit = blink_en[2];
        an_sel    = AN_R;
      end
      DIG_Y: begin
        code      = frame_q[Y_LSB +: 5];
        blink_bit = blink_en[1];
        an_sel    = AN_Y;
      end
      DIG_B: begin
        code      = frame_q[B_LSB +: 5];
        blink_bit = blink_en[0];
        an_sel    = AN_B;
      end
      default: ;
    endcase
  end

  seg7_dec u_dec (
    .code_i (code),
    .seg_o  (dec_seg)
  );

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (cnt_q >= CW'(BLANK_CYC)) begin
      an_d  = an_sel;
      seg_d = (phase_q && blink_bit) ? SEG_OFF : dec_seg;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule
